// File: rtl/rpn_stack_exec.sv
// RPN calculator stack executor: accepts PUSH/POP/arithmetic/CLEAR commands,
// keeps top-of-stack cached in a register and drives a single-port stack RAM.
module rpn_stack_exec #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic [DW-1:0] tos,
  output logic [AW:0]   depth,
  output logic          underflow,
  output logic          overflow,
  output logic [1:0]    dbg_state
);

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_POP   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  localparam logic [AW:0] SP_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0] SP_TWO  = (AW+1)'(2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WRITE   = 2'd3
  } state_e;

  state_e        state;
  logic [AW:0]   sp;
  logic [2:0]    op_r;
  logic [AW:0]   sp_m2;
  logic [DW-1:0] alu_r;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high exactly while IDLE, and inputs are ignored otherwise.
  assign cmd_ready = (state == IDLE);
  assign depth     = sp;
  assign dbg_state = state;
  assign sp_m2     = sp - SP_TWO;

  // Second operand comes from RAM, first from the cached top: SUB is second - top.
  always_comb begin
    alu_r = '0;
    case (op_r)
      OP_ADD:  alu_r = ram_q + tos;
      OP_SUB:  alu_r = ram_q - tos;
      OP_AND:  alu_r = ram_q & tos;
      OP_OR:   alu_r = ram_q | tos;
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sp        <= '0;
      tos       <= '0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_wren  <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      op_r      <= OP_PUSH;
    end else begin
      case (state)
        IDLE: begin
          ram_wren <= 1'b0;
          if (cmd_valid) begin
            case (cmd_op)
              OP_PUSH: begin
                if (sp == SP_FULL) begin
                  overflow <= 1'b1;
                end else begin
                  ram_addr <= sp[AW-1:0];
                  ram_data <= cmd_data;
                  ram_wren <= 1'b1;
                  tos      <= cmd_data;
                  sp       <= sp + SP_ONE;
                  state    <= WRITE;
                end
              end
              OP_POP: begin
                if (sp == '0) begin
                  underflow <= 1'b1;
                end else if (sp == SP_ONE) begin
                  sp  <= '0;
                  tos <= '0;
                end else begin
                  // New top lives at sp-2; fetch it to refill the cache.
                  ram_addr <= sp_m2[AW-1:0];
                  sp       <= sp - SP_ONE;
                  op_r     <= cmd_op;
                  state    <= RD_ADDR;
                end
              end
              OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                if (sp < SP_TWO) begin
                  underflow <= 1'b1;
                end else begin
                  ram_addr <= sp_m2[AW-1:0];
                  op_r     <= cmd_op;
                  state    <= RD_ADDR;
                end
              end
              OP_CLEAR: begin
                sp        <= '0;
                tos       <= '0;
                underflow <= 1'b0;
                overflow  <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          if (op_r == OP_POP) begin
            tos   <= ram_q;
            state <= IDLE;
          end else begin
            // Result overwrites the second operand's slot, which becomes the top.
            ram_data <= alu_r;
            ram_wren <= 1'b1;
            tos      <= alu_r;
            sp       <= sp - SP_ONE;
            state    <= WRITE;
          end
        end
        WRITE: begin
          ram_wren <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
